uio_bus_scheduler: RTL
======================

// Module: uio_bus_scheduler
// PURPOSE
//  Time-shares the 8-bit bidirectional uio pad bus of tt_um_experiment_number_six
//  between NREQ internal requesters. Grants are round-robin with a bounded hold
//  time. A turnaround gap with uio_oe=0 is inserted between owners. Owns uio_out
//  and uio_oe exclusively; the top level wires these straight to the pads.
// PARAMETERS
//  NREQ        4   number of requesters (2..8)
//  MAX_HOLD    16  max cycles one grant may last before forced release (>=2)
//  TURNAROUND  1   idle cycles with uio_oe=0 before each new grant (0..3)
// PORTS
//  clk        in   1        system clock, all logic rising-edge
//  rst        in   1        synchronous, active-high reset
//  ena        in   1        design enable; 0 freezes FSM, counters and outputs
//  req        in   NREQ     request per requester, level, held until granted/done
//  dir        in   NREQ     1 = requester drives pads, 0 = requester reads pads
//  wdata      in   NREQ*8   write data; slice i = wdata[8*i+7:8*i]
//  done       in   NREQ     1-cycle pulse from owner: release the bus
//  gnt        out  NREQ     registered one-hot grant (all-zero when no owner)
//  rdata      out  8        registered sample of uio_in during read ownership
//  rvalid     out  1        rdata valid this cycle
//  busy       out  1        FSM not in IDLE
//  uio_in     in   8        pad inputs
//  uio_out    out  8        pad outputs
//  uio_oe     out  8        pad output enables (1 = drive)
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, gnt=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0, busy=0.
//  FSM states IDLE, TURN, OWN (all transitions on clk edge with ena=1):
//   IDLE: if |req, sel = first i with req[i] searching ptr,ptr+1..(mod NREQ);
//         latch sel and dir[sel]; go TURN with tcnt=TURNAROUND (OWN if TURNAROUND=0).
//   TURN: uio_oe=0; tcnt decrements; at tcnt==0 -> OWN, gnt[sel]=1, hcnt=0.
//         If req[sel] drops during TURN -> IDLE, ptr unchanged, no grant issued.
//   OWN:  hcnt increments each cycle. Release when done[sel], or !req[sel], or
//         hcnt==MAX_HOLD-1 (forced). Release -> IDLE, gnt=0, ptr=(sel+1)%NREQ.
//         Simultaneous release causes = one release, no extra cycle.
//  Latency (TURNAROUND=1): req seen at edge k -> TURN after k -> gnt high after k+1.
//  Minimum gap between two grants: 1 (IDLE) + TURNAROUND cycles, uio_oe=0 throughout.
//  Direction is latched at selection; dir changes during TURN/OWN are ignored.
//  Pad drive (combinational from state): OWN & write -> uio_oe=8'hFF,
//   uio_out=wdata slice of sel; otherwise uio_oe=8'h00, uio_out=8'h00.
//  Read path: in OWN & read, rdata<=uio_in and rvalid<=1 each cycle (1-cycle
//   latency); rvalid<=0 otherwise; rdata holds last value.
//  done from a non-owner is ignored. req from owner re-asserted after release
//   competes normally (ptr already past it: fairness guaranteed).
//  ena=0: no state, counter or register update; outputs hold.
//  rst mid-OWN: next cycle gnt=0 and uio_oe=0 immediately, ptr=0.
//  Single-requester continuous req: released at MAX_HOLD, re-granted after gap.
// TESTING
//  1. rst=1 2 cycles, req=4'b0001 dir[0]=1 wdata0=8'hA5 -> gnt=0001 at k+2,
//     uio_oe=FF uio_out=A5 while owned; done0 pulse -> gnt=0, uio_oe=0 next cycle.
//  2. req=4'b1111 held, done pulsed each grant -> grant order 0,1,2,3,0 with
//     2-cycle uio_oe=0 gap between each owner.
//  3. req[2] only, dir[2]=0, uio_in=8'h3C -> rvalid=1, rdata=3C one cycle after
//     grant; uio_oe stays 00 for whole transaction.
//  4. req[1] held 40 cycles, no done, MAX_HOLD=16 -> gnt[1] high exactly 16 cycles,
//     low 2 cycles, re-granted; also req[3] present -> req[3] granted first.
//  5. req[0] dropped during TURN -> no gnt, back to IDLE, ptr still 0;
//     ena=0 for 5 cycles mid-OWN -> hcnt and outputs frozen, resumes on ena=1.
//  6. rst asserted mid-OWN (write) -> next cycle gnt=0, uio_oe=00, busy=0.

Source files
------------

// File: rtl/uio_bus_scheduler.sv
// uio_bus_scheduler: round-robin time-sharing of the uio pad bus with bounded hold and turnaround gap
module uio_bus_scheduler #(
  parameter int NREQ       = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
  input  logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     ptr_q, ptr_d, sel_q, sel_d, pick;
  logic              dir_q, dir_d, rvalid_q, rvalid_d, rel;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [1:0]        tcnt_q, tcnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        rdata_q, rdata_d;

  function automatic logic [SW-1:0] wrap(input int s);
    return SW'(s >= NREQ ? s - NREQ : s);
  endfunction

  // Descending scan so the requester closest to ptr wins
  always_comb begin
    pick = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[wrap(int'(ptr_q) + k)]) pick = wrap(int'(ptr_q) + k);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    hcnt_d   = hcnt_q;
    tcnt_d   = tcnt_q;
    gnt_d    = gnt_q;
    rvalid_d = (state_q == OWN) && !dir_q;
    rdata_d  = rvalid_d ? uio_in : rdata_q;
    rel      = done[sel_q] || !req[sel_q] || (hcnt_q == HW'(MAX_HOLD - 1));
    if (state_q == IDLE && |req) begin
      sel_d = pick;
      dir_d = dir[pick];
      if (TURNAROUND == 0) begin
        state_d = OWN;
        gnt_d   = NREQ'(1) << pick;
        hcnt_d  = '0;
      end else begin
        state_d = TURN;
        tcnt_d  = 2'(TURNAROUND - 1);
      end
    end else if (state_q == TURN) begin
      if (!req[sel_q]) state_d = IDLE;
      else if (tcnt_q == '0) begin
        state_d = OWN;
        gnt_d   = NREQ'(1) << sel_q;
        hcnt_d  = '0;
      end else tcnt_d = tcnt_q - 2'd1;
    end else if (state_q == OWN) begin
      hcnt_d = hcnt_q + 1'b1;
      if (rel) begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = wrap(int'(sel_q) + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      dir_q    <= 1'b0;
      hcnt_q   <= '0;
      tcnt_q   <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      hcnt_q   <= hcnt_d;
      tcnt_q   <= tcnt_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = state_q != IDLE;
  assign uio_oe  = (state_q == OWN && dir_q) ? 8'hFF : 8'h00;
  assign uio_out = (state_q == OWN && dir_q) ? wdata[8*sel_q +: 8] : 8'h00;
endmodule
